// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader and its write stage.
//   - state_t     : loader controller states
//   - LANES       : number of byte lanes per instruction word (48-bit word)
//   - LANE_FIRST  : first lane written for an instruction (most significant)
//   - LANE_LAST   : last lane written for an instruction (least significant)
//   - lane_strobe : converts a lane number (1..LANES) into an active-low
//                   one-hot strobe vector; bit k-1 drives ROM lane k
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN adds the S_CSUM state.
// ----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int LANES = 6;

    // Lanes are filled from the most significant byte down to the least.
    localparam logic [2:0] LANE_FIRST = 3'(LANES);
    localparam logic [2:0] LANE_LAST  = 3'd1;

    localparam logic [LANES-1:0] STROBE_IDLE = '1;

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    // Lane numbers outside 1..LANES produce an all-high (idle) strobe.
    function automatic logic [LANES-1:0] lane_strobe(input logic [2:0] lane);
        logic [LANES-1:0] s;
        s = STROBE_IDLE;
        for (int k = 0; k < LANES; k++) begin
            if (int'(lane) == k + 1) begin
                s[k] = 1'b0;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Byte-stream link from the host to the loader (valid/ready handshake).
//   in_data  : byte from the host
//   in_valid : in_data is valid this cycle
//   in_ready : loader accepts in_data this cycle
// Modports: master = host side, slave = loader side.
// ----------------------------------------------------------------------------
interface program_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/program_loader_wr_stage.sv
// ----------------------------------------------------------------------------
// loader_wr_stage
// Registered write stage between the loader controller and program memory.
// One write request per cycle is captured and presented for exactly one
// cycle as address, data and an active-low one-hot lane strobe.
// Ports:
//   clk, _mr       : clock, asynchronous active-low reset
//   wr_en          : capture a write this cycle
//   lane           : lane number 1..LANES for the captured write
//   addr_in/data_in: address and byte to be written
//   wr_addr/wr_data: registered address/byte (hold their last value)
//   _we_lane       : active-low lane strobes, all high when idle
// ----------------------------------------------------------------------------
module loader_wr_stage
    import program_loader_pkg::*;
#(
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              _mr,
    input  logic              wr_en,
    input  logic [2:0]        lane,
    input  logic [AWIDTH-1:0] addr_in,
    input  logic [7:0]        data_in,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [LANES-1:0]  _we_lane
);

    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [LANES-1:0]  we_q,   we_d;

    // The strobe falls back to idle every cycle without a request, so each
    // write lasts exactly one cycle; address and data simply hold.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        we_d   = STROBE_IDLE;
        if (wr_en) begin
            addr_d = addr_in;
            data_d = data_in;
            we_d   = lane_strobe(lane);
        end
    end

    // Asynchronous reset releases the strobe immediately, aborting any
    // write that is in flight.
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= STROBE_IDLE;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
        end
    end

    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign _we_lane = we_q;

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Receives a program image over a byte link and writes it into a 6-lane
// (48-bit) instruction ROM while holding the CPU.
// Frame: addr_hi, addr_lo, count_hi, count_lo, then count*6 payload bytes
// (lane 6 first). With PROGRAM_LOADER_CHECKSUM_EN defined, a trailing byte
// equal to the XOR of all payload bytes follows and a mismatch sets err.
// Ports:
//   clk, _mr   : clock, asynchronous active-low master reset
//   host       : byte link (slave modport of program_loader_if)
//   wr_addr    : program-memory address being written
//   wr_data    : byte for the lane being written
//   _we_lane   : active-low per-lane write strobes (bit k-1 = lane k)
//   _cpu_hold  : active-low CPU hold while a load is in progress
//   done       : one-cycle pulse when a load completes
//   err        : sticky checksum-failure flag (0 without the checksum build)
// ----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              _mr,
    program_loader_if.slave   host,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [LANES-1:0]  _we_lane,
    output logic              _cpu_hold,
    output logic              done,
    output logic              err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic [2:0]        lane_q, lane_d;
    logic              hold_q, hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    logic accept;
    logic wr_en;

    // Gated by _mr so nothing is accepted while reset is held.
    assign host.in_ready = _mr && (state_q != S_DONE);
    assign accept        = host.in_valid && host.in_ready;

    // Next-state logic: every accepted byte advances exactly one step.
    // The high header byte is parked in hi_q and combined with the low byte.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        count_d = count_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_ADDR_HI: begin
                if (accept) begin
                    hi_d    = host.in_data;
                    hold_d  = 1'b0;
                    state_d = S_ADDR_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_ADDR_LO: begin
                if (accept) begin
                    addr_d  = AWIDTH'({hi_q, host.in_data});
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    hi_d    = host.in_data;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    count_d = {hi_q, host.in_data};
                    lane_d  = LANE_FIRST;
                    state_d = ({hi_q, host.in_data} == 16'd0) ? END_STATE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ host.in_data;
`endif
                    // Finishing lane 1 completes an instruction word; the
                    // address wraps naturally at the top of memory.
                    if (lane_q == LANE_LAST) begin
                        lane_d  = LANE_FIRST;
                        addr_d  = addr_q + AWIDTH'(1);
                        count_d = count_q - 16'd1;
                        if (count_q == 16'd1) begin
                            state_d = END_STATE;
                        end
                    end else begin
                        lane_d = lane_q - 3'd1;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    err_d   = (csum_q != host.in_data);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                hold_d  = 1'b1;
                state_d = S_ADDR_HI;
            end
            default: begin
                state_d = S_ADDR_HI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            state_q <= S_ADDR_HI;
            hi_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
            lane_q  <= LANE_FIRST;
            hold_q  <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    loader_wr_stage #(
        .AWIDTH (AWIDTH)
    ) u_wr_stage (
        .clk      (clk),
        ._mr      (_mr),
        .wr_en    (wr_en),
        .lane     (lane_q),
        .addr_in  (addr_q),
        .data_in  (host.in_data),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        ._we_lane (_we_lane)
    );

    assign _cpu_hold = hold_q;
    assign done      = (state_q == S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader: a cycle table for a single-word
// frame, plus directed sequences for address wrap, empty frames, checksum
// handling (PROGRAM_LOADER_CHECKSUM_EN builds), mid-write reset and
// throttled input. Written words are captured from the strobes and compared
// against expectations derived from the frame contents.
// ----------------------------------------------------------------------------
module tb_program_loader;

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        ready;
        logic [5:0]  we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        hold;
        logic        done;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  lane;
        logic [7:0]  data;
    } wr_rec_t;

    logic        clk = 1'b0;
    logic        _mr;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  _we_lane;
    logic        _cpu_hold;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int multi_strobe = 0;

    logic [7:0] tx_q[$];
    logic [7:0] pl_q[$];
    wr_rec_t    wr_log[$];
    wr_rec_t    exp_q[$];
    wr_rec_t    ref_log[$];
    vec_t       vecs[$];

    program_loader_if host ();

    program_loader #(
        .AWIDTH (16)
    ) dut (
        .clk       (clk),
        ._mr       (_mr),
        .host      (host),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        ._we_lane  (_we_lane),
        ._cpu_hold (_cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: records every single-lane write and counts cycles
    // with more than one strobe low.
    always @(negedge clk) begin
        int lows;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
            if (_we_lane[k] == 1'b0) lows++;
        end
        if (lows > 1) begin
            multi_strobe++;
        end else if (lows == 1) begin
            for (int k = 0; k < 6; k++) begin
                if (_we_lane[k] == 1'b0) wr_log.push_back('{wr_addr, 3'(k + 1), wr_data});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_frame(input logic [15:0] addr, input logic [15:0] n);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (pl_q[i]) x ^= pl_q[i];
`endif
        tx_q.delete();
        tx_q.push_back(addr[15:8]);
        tx_q.push_back(addr[7:0]);
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        foreach (pl_q[i]) tx_q.push_back(pl_q[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx_q.push_back(x);
`endif
    endtask

    // Expected ROM writes: lane 6 first, one word per six payload bytes.
    task automatic expect_writes(input logic [15:0] addr);
        exp_q.delete();
        foreach (pl_q[i]) begin
            exp_q.push_back('{16'(addr + 16'(i / 6)), 3'(6 - (i % 6)), pl_q[i]});
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_write_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            check($sformatf("%s_addr[%0d]", tag, i), wr_log[i].addr, exp_q[i].addr);
            check($sformatf("%s_lane[%0d]", tag, i), wr_log[i].lane, exp_q[i].lane);
            check($sformatf("%s_data[%0d]", tag, i), wr_log[i].data, exp_q[i].data);
        end
    endtask

    // Streams tx_q; with gaps set, in_valid is dropped on random cycles.
    // Returns after the edge that accepts the final byte.
    task automatic apply_stimulus(input bit gaps, output int stalls);
        stalls = 0;
        foreach (tx_q[i]) begin
            bit sent;
            int budget;
            sent   = 1'b0;
            budget = 0;
            while (!sent) begin
                @(negedge clk);
                host.in_data  = tx_q[i];
                host.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                #1;
                if (host.in_valid && host.in_ready) sent = 1'b1;
                else if (host.in_valid) stalls++;
                budget++;
                if (!sent && budget > 50) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    sent = 1'b1;
                end
                @(posedge clk);
            end
        end
        #1;
        host.in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        int  lat;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency", lat, 0);
        if (seen) begin
            check("err_at_done", 32'(err), 32'(exp_err));
            check("ready_in_done", 32'(host.in_ready), 32'd0);
            check("hold_in_done", 32'(_cpu_hold), 32'd0);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("hold_released", 32'(_cpu_hold), 32'd1);
        end
    endtask

    task automatic push_vec(input logic [7:0] d, input logic v, input logic r,
                            input logic [5:0] we, input logic [15:0] a,
                            input logic [7:0] wd, input logic h, input logic dn);
        vecs.push_back('{d, v, r, we, a, wd, h, dn});
    endtask

    initial begin
        int stalls;

        host.in_data  = 8'h00;
        host.in_valid = 1'b0;
        _mr           = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_we_lane", 32'(_we_lane), 32'h3F);
        check("rst_cpu_hold", 32'(_cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(host.in_ready), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        _mr = 1'b1;
        #1;
        check("ready_after_rst", 32'(host.in_ready), 32'd1);

        // ---------------- cycle table: single word at 0x0010 ----------------
        push_vec(8'h00, 1, 1, 6'h3F, 16'h0000, 8'h00, 0, 0);
        push_vec(8'h10, 1, 1, 6'h3F, 16'h0000, 8'h00, 0, 0);
        push_vec(8'h00, 1, 1, 6'h3F, 16'h0000, 8'h00, 0, 0);
        push_vec(8'h01, 1, 1, 6'h3F, 16'h0000, 8'h00, 0, 0);
        push_vec(8'hAA, 1, 1, 6'h1F, 16'h0010, 8'hAA, 0, 0);
        push_vec(8'h99, 0, 1, 6'h3F, 16'h0000, 8'h00, 0, 0);
        push_vec(8'hBB, 1, 1, 6'h2F, 16'h0010, 8'hBB, 0, 0);
        push_vec(8'hCC, 1, 1, 6'h37, 16'h0010, 8'hCC, 0, 0);
        push_vec(8'hDD, 1, 1, 6'h3B, 16'h0010, 8'hDD, 0, 0);
        push_vec(8'hEE, 1, 1, 6'h3D, 16'h0010, 8'hEE, 0, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        push_vec(8'hFF, 1, 1, 6'h3E, 16'h0010, 8'hFF, 0, 0);
        push_vec(8'h11, 1, 0, 6'h3F, 16'h0000, 8'h00, 0, 1);
`else
        push_vec(8'hFF, 1, 0, 6'h3E, 16'h0010, 8'hFF, 0, 1);
`endif
        push_vec(8'h00, 0, 1, 6'h3F, 16'h0000, 8'h00, 1, 0);
        push_vec(8'h00, 0, 1, 6'h3F, 16'h0000, 8'h00, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            host.in_data  = vecs[i].data;
            host.in_valid = vecs[i].valid;
            @(posedge clk);
            #1;
            check($sformatf("tbl_ready[%0d]", i), 32'(host.in_ready), 32'(vecs[i].ready));
            check($sformatf("tbl_we[%0d]", i), 32'(_we_lane), 32'(vecs[i].we));
            check($sformatf("tbl_hold[%0d]", i), 32'(_cpu_hold), 32'(vecs[i].hold));
            check($sformatf("tbl_done[%0d]", i), 32'(done), 32'(vecs[i].done));
            if (vecs[i].we != 6'h3F) begin
                check($sformatf("tbl_addr[%0d]", i), 32'(wr_addr), 32'(vecs[i].addr));
                check($sformatf("tbl_wdata[%0d]", i), 32'(wr_data), 32'(vecs[i].wdata));
            end
        end
        host.in_valid = 1'b0;
        $display("[TB] cycle table applied");

        // ---------------- address wrap, back-to-back ----------------
        pl_q.delete();
        for (int i = 1; i <= 12; i++) pl_q.push_back(8'(i));
        build_frame(16'hFFFF, 16'd2);
        expect_writes(16'hFFFF);
        @(negedge clk);
        wr_log.delete();
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
        check("wrap_stalls", stalls, 0);
        check_log("wrap");

        // ---------------- empty frame ----------------
        pl_q.delete();
        build_frame(16'h1234, 16'd0);
        exp_q.delete();
        wr_log.delete();
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
        check_log("empty");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // ---------------- checksum good / bad / clear ----------------
        tx_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
        tx_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        apply_stimulus(1'b0, stalls);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        tx_q = '{8'h00};
        apply_stimulus(1'b0, stalls);
        check("err_cleared", 32'(err), 32'd0);
        tx_q = '{8'h40, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
`endif

        // ---------------- reset during the lane-3 write ----------------
        pl_q.delete();
        for (int i = 0; i < 18; i++) pl_q.push_back(8'(8'h40 + i));
        build_frame(16'h0200, 16'd3);
        tx_q = tx_q[0:7];
        apply_stimulus(1'b0, stalls);
        check("mid_we_lane3", 32'(_we_lane), 32'h3B);
        check("mid_wr_data", 32'(wr_data), 32'h43);
        check("mid_hold", 32'(_cpu_hold), 32'd0);
        #1;
        _mr = 1'b0;
        #1;
        check("arst_we_lane", 32'(_we_lane), 32'h3F);
        check("arst_hold", 32'(_cpu_hold), 32'd1);
        check("arst_ready", 32'(host.in_ready), 32'd0);
        check("arst_wr_addr", 32'(wr_addr), 32'd0);
        wr_log.delete();
        repeat (2) @(negedge clk);
        check("arst_no_writes", wr_log.size(), 0);
        _mr = 1'b1;
        #1;
        check("arst_ready_after", 32'(host.in_ready), 32'd1);
        pl_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        build_frame(16'h0300, 16'd1);
        expect_writes(16'h0300);
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
        check_log("after_rst");

        // ---------------- throttled input vs back-to-back ----------------
        pl_q.delete();
        for (int i = 0; i < 24; i++) pl_q.push_back(8'(i * 13 + 5));
        build_frame(16'h0100, 16'd4);
        expect_writes(16'h0100);
        wr_log.delete();
        apply_stimulus(1'b0, stalls);
        wait_done(1'b0);
        check_log("b2b");
        ref_log = wr_log;
        wr_log.delete();
        apply_stimulus(1'b1, stalls);
        wait_done(1'b0);
        check_log("gaps");
        check("gaps_vs_b2b_count", wr_log.size(), ref_log.size());
        for (int i = 0; i < ref_log.size() && i < wr_log.size(); i++) begin
            check($sformatf("gaps_vs_b2b[%0d]", i), {13'd0, wr_log[i].lane, wr_log[i].addr},
                  {13'd0, ref_log[i].lane, ref_log[i].addr});
        end
        check("multi_strobe_cycles", multi_strobe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter AWIDTH, default 16: program-memory address width, matching the instruction ROM address (pc) width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 _mr  input  1  master reset; asynchronous, active-low.
REQ-004 in_data  input  8  byte from host link.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  loader accepts in_data this cycle; a byte is accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 wr_addr  output  AWIDTH  program-memory address of the instruction being written.
REQ-008 wr_data  output  8  byte for the lane being written.
REQ-009 _we_lane  output  6  active-low per-lane write strobes; bit k-1 drives ROM lane k (lane 6 = instruction[47:40] ... lane 1 = instruction[7:0]).
REQ-010 _cpu_hold  output  1  active-low; holds the CPU while a load is in progress.
REQ-011 done  output  1  one-cycle pulse when a load completes.
REQ-012 err  output  1  sticky checksum-failure flag (REQ-030).

Function
REQ-013 States: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, DONE. Each accepted byte advances exactly one step.
REQ-014 Frame: start address (hi, lo), instruction count N (hi, lo), then N*6 payload bytes; optional checksum byte per REQ-029.
REQ-015 ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO on each accepted byte; each byte is latched into the address or count register.
REQ-016 CNT_LO with N=0 -> CSUM if checksum is enabled, else DONE; with N>0 -> DATA, lane counter = 6.
REQ-017 In DATA, the byte accepted at edge E drives wr_data at E+1, with wr_addr = current address and exactly one _we_lane bit (current lane) low for that single cycle.
REQ-018 Lane order within an instruction is 6,5,4,3,2,1.
REQ-019 After lane 1: address increments by 1, N decrements, lane counter reloads to 6.
REQ-020 The last lane-1 byte of the last instruction -> CSUM if checksum is enabled, else DONE.
REQ-021 Address increment wraps modulo 2^AWIDTH (0xFFFF -> 0x0000) with no error.
REQ-022 DONE lasts one cycle: done=1 and in_ready=0, then -> ADDR_HI.
REQ-023 in_ready=1 in every state except DONE; sustained throughput is one byte per cycle.
REQ-024 _cpu_hold goes low on the cycle after the ADDR_HI byte is accepted and returns high in the cycle after DONE.
REQ-025 At most one _we_lane bit is low in any cycle. Bytes presented while in_valid=0 are ignored. No write strobe is issued outside DATA.
REQ-026 Count arithmetic is 16-bit unsigned; N ranges 0..65535.

Reset
REQ-027 While _mr is low: state=ADDR_HI, _we_lane=6'h3F, _cpu_hold=1, done=0, err=0, in_ready=0, wr_addr=0, wr_data=0, lane counter=6, count=0, checksum accumulator=0.
REQ-028 Reset mid-frame (including mid-write-cycle) abandons the frame; the write strobe deasserts asynchronously and no partial write completes after _mr rises.

Configuration
REQ-029 Macro PROGRAM_LOADER_CHECKSUM_EN defined: the frame carries a trailing byte equal to the XOR of all payload bytes (headers excluded); the CSUM state accepts it, then -> DONE.
REQ-030 With the macro defined: on mismatch, err=1 in the DONE cycle and it stays 1 until reset or until the next ADDR_HI byte is accepted; data already written is not rolled back.
REQ-031 Macro undefined: CSUM state and accumulator are absent, err is tied to 0, and the frame has no trailing byte.

Structure
REQ-032 Shared package program_loader_pkg holds the state enum, LANES=6, and the lane-order constant; the controller's ROM lane numbering references the same constants.
REQ-033 One sub-module, loader_wr_stage: the registered write stage (addr, data, one-hot-low strobe) with asynchronous reset.

Verification
REQ-034 Frame 00 10 00 01 AA BB CC DD EE FF -> six strobes at address 0x0010: lane6=AA, lane5=BB, ... lane1=FF; then done pulse, _cpu_hold high.
REQ-035 Start FFFF, N=2, bytes 01..0C streamed back-to-back -> lanes 6..1 at 0xFFFF get 01..06, lanes 6..1 at 0x0000 get 07..0C; no stall cycles.
REQ-036 N=0 -> no strobes; done pulses one cycle after the CNT_LO byte is accepted (checksum disabled).
REQ-037 Checksum enabled, payload 11 22 33 44 55 66, trailing 77 -> err=0; trailing 00 -> err=1 and stays set until the next frame starts.
REQ-038 Assert _mr during the lane-3 write of N=3 -> strobes are high immediately, state is ADDR_HI, and a fresh frame loads correctly afterwards.
REQ-039 in_valid toggled randomly across a 4-instruction frame -> memory contents identical to a back-to-back run, and never more than one strobe low per cycle.
